// File: rtl/tdm_pkg.sv
// Shared constants, state type and round-robin helper for the 8-channel TDM mux.
package tdm_pkg;

  localparam int N_CH  = 8;
  localparam int SEL_W = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Returns {found, idx}: the first valid channel at or after ptr, wrapping mod N_CH.
  function automatic logic [SEL_W:0] rr_pick(input logic [N_CH-1:0] valid,
                                             input logic [SEL_W-1:0] ptr);
    logic [SEL_W-1:0] idx;
    rr_pick = '0;
    // Walk from the far end backwards so the nearest valid channel wins last.
    for (int unsigned k = 0; k < N_CH; k++) begin
      idx = ptr + SEL_W'(N_CH - 1 - k);
      if (valid[idx]) rr_pick = {1'b1, idx};
    end
  endfunction

endpackage

// File: rtl/tdm_mux_8x1_rr_arbiter.sv
// Combinational round-robin pick: rotate by ptr, priority-encode, unrotate.
module rr_arbiter_8
  import tdm_pkg::*;
(
  input  logic [N_CH-1:0]  i_valid,
  input  logic [SEL_W-1:0] i_ptr,
  output logic             o_found,
  output logic [SEL_W-1:0] o_idx
);

  logic [N_CH-1:0]  w_rot;
  logic [SEL_W-1:0] w_enc;

  // w_rot[k] = i_valid[(i_ptr + k) mod 8]
  assign w_rot = N_CH'({i_valid, i_valid} >> i_ptr);

  always_comb begin
    w_enc = '0;
    for (int unsigned k = N_CH; k > 0; k--) begin
      if (w_rot[k-1]) w_enc = SEL_W'(k - 1);
    end
  end

  assign o_found = |w_rot;
  assign o_idx   = w_enc + i_ptr;

endmodule

// File: rtl/tdm_mux_8x1.sv
// 8-to-1 TDM mux: round-robin or fixed-slot arbitration into a registered valid/ready stage.
module tdm_mux_8x1
  import tdm_pkg::*;
#(
  parameter int WIDTH     = 1,
  parameter bit SKIP_IDLE = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic [8*WIDTH-1:0]    ch_data,
  input  logic [7:0]            ch_valid,
  output logic [7:0]            ch_ack,
  output logic [WIDTH-1:0]      out_data,
  output logic [2:0]            out_sel,
  output logic                  out_valid,
  output logic                  out_empty,
  output logic                  out_last,
  input  logic                  out_ready
);

  state_t           r_state;
  logic [SEL_W-1:0] r_ptr;
  logic [SEL_W-1:0] r_sel;
  logic [WIDTH-1:0] r_data;
  logic             r_valid;
  logic             r_empty;

  logic             w_free;
  logic             w_accept;
  logic             w_found;
  logic [SEL_W-1:0] w_idx;
  logic [SEL_W-1:0] w_slot;
  logic             w_hit;
  logic             w_load;
  logic [WIDTH-1:0] w_item;

  rr_arbiter_8 u_arb (
    .i_valid (ch_valid),
    .i_ptr   (r_ptr),
    .o_found (w_found),
    .o_idx   (w_idx)
  );

  assign w_free   = !r_valid || out_ready;
  assign w_accept = r_valid && out_ready;
  assign w_slot   = SKIP_IDLE ? w_idx : r_ptr;
  assign w_hit    = ch_valid[w_slot];
  assign w_item   = ch_data[w_slot*WIDTH +: WIDTH];

  // Enable is checked before arbitration, so a falling enable suppresses the grant.
  assign w_load = (r_state == RUN) && enable && w_free && (SKIP_IDLE ? w_found : 1'b1);

  always_comb begin
    ch_ack = '0;
    if (w_load && w_hit) ch_ack[w_slot] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_sel   <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_empty <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (enable) r_state <= RUN;
        end
        RUN: begin
          if (!enable) begin
            r_state <= DRAIN;
            if (w_accept) begin
              r_valid <= 1'b0;
              r_empty <= 1'b0;
            end
          end else if (w_load) begin
            r_valid <= 1'b1;
            r_sel   <= w_slot;
            r_data  <= w_hit ? w_item : '0;
            r_empty <= !w_hit;
            r_ptr   <= w_slot + 3'd1;
          end else if (w_accept) begin
            r_valid <= 1'b0;
            r_empty <= 1'b0;
          end
        end
        DRAIN: begin
          if (!r_valid || out_ready) begin
            r_state <= IDLE;
            r_valid <= 1'b0;
            r_empty <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign out_data  = r_data;
  assign out_sel   = r_sel;
  assign out_valid = r_valid;
  assign out_empty = r_empty;
  assign out_last  = r_valid && (r_sel == 3'd7);

endmodule

// File: tb/tb_tdm_mux_8x1.sv
// Bench for tdm_mux_8x1: round-robin and fixed-slot instances against a transaction-level model.
module tb_tdm_mux_8x1;

  localparam int W = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           enable;
  logic           out_ready;
  logic [8*W-1:0] ch_data;
  logic [7:0]     ch_valid;

  logic [7:0]     ack_s, ack_t;
  logic [W-1:0]   data_s, data_t;
  logic [2:0]     sel_s, sel_t;
  logic           vld_s, vld_t, emp_s, emp_t, last_s, last_t;

  always #5 clk = ~clk;

  tdm_mux_8x1 #(.WIDTH(W), .SKIP_IDLE(1'b1)) u_skip (
    .clk(clk), .rst_n(rst_n), .enable(enable), .ch_data(ch_data), .ch_valid(ch_valid),
    .ch_ack(ack_s), .out_data(data_s), .out_sel(sel_s), .out_valid(vld_s),
    .out_empty(emp_s), .out_last(last_s), .out_ready(out_ready)
  );

  tdm_mux_8x1 #(.WIDTH(W), .SKIP_IDLE(1'b0)) u_tdm (
    .clk(clk), .rst_n(rst_n), .enable(enable), .ch_data(ch_data), .ch_valid(ch_valid),
    .ch_ack(ack_t), .out_data(data_t), .out_sel(sel_t), .out_valid(vld_t),
    .out_empty(emp_t), .out_last(last_t), .out_ready(out_ready)
  );

  int tests = 0;
  int fails = 0;

  // Model per instance: index 0 = round-robin, 1 = fixed slot.
  // running/draining describe the run request lifecycle; held item is a one-deep buffer.
  int running [2] = '{default: 0};
  int draining[2] = '{default: 0};
  int ptr     [2] = '{default: 0};
  int hv      [2] = '{default: 0};
  int hd      [2] = '{default: 0};
  int hs      [2] = '{default: 0};
  int he      [2] = '{default: 0};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] pred_ack(input int m);
    logic [7:0] a;
    a = '0;
    if (running[m] != 0 && draining[m] == 0 && enable && (hv[m] == 0 || out_ready)) begin
      if (m == 0) begin
        for (int k = 0; k < 8; k++) begin
          int c;
          c = (ptr[m] + k) % 8;
          if (ch_valid[c]) begin
            a[c] = 1'b1;
            break;
          end
        end
      end else begin
        a[ptr[m]] = ch_valid[ptr[m]];
      end
    end
    return a;
  endfunction

  task automatic model_step(input int m, input logic [7:0] a);
    int c;
    if (!rst_n) begin
      running[m] = 0; draining[m] = 0; ptr[m] = 0;
      hv[m] = 0; hd[m] = 0; hs[m] = 0; he[m] = 0;
    end else if (running[m] == 0) begin
      if (enable) running[m] = 1;
    end else if (draining[m] != 0) begin
      if (hv[m] == 0 || out_ready) begin
        running[m] = 0; draining[m] = 0; hv[m] = 0;
      end
    end else if (!enable) begin
      draining[m] = 1;
      if (hv[m] != 0 && out_ready) hv[m] = 0;
    end else if (hv[m] == 0 || out_ready) begin
      if (a != 0) begin
        c = $clog2(a);
        hv[m] = 1; hs[m] = c; hd[m] = ch_data[c*W +: W]; he[m] = 0;
        ptr[m] = (c + 1) % 8;
      end else if (m == 1) begin
        hv[m] = 1; hs[m] = ptr[m]; hd[m] = 0; he[m] = 1;
        ptr[m] = (ptr[m] + 1) % 8;
      end else begin
        hv[m] = 0;
      end
    end
  endtask

  // Check both instances in the low phase, advance the model, return just after the edge.
  task automatic cycle();
    logic [7:0] a [2];
    @(negedge clk);
    for (int m = 0; m < 2; m++) begin
      a[m] = pred_ack(m);
      chk(m == 0 ? "rr_ack"  : "tdm_ack",  m == 0 ? ack_s : ack_t, a[m]);
      chk(m == 0 ? "rr_vld"  : "tdm_vld",  m == 0 ? vld_s : vld_t, hv[m]);
      chk(m == 0 ? "rr_last" : "tdm_last", m == 0 ? last_s : last_t,
          (hv[m] != 0 && hs[m] == 7) ? 1 : 0);
      if (hv[m] != 0) begin
        chk(m == 0 ? "rr_sel"  : "tdm_sel",  m == 0 ? sel_s : sel_t, hs[m]);
        chk(m == 0 ? "rr_data" : "tdm_data", m == 0 ? data_s : data_t, hd[m]);
        chk(m == 0 ? "rr_emp"  : "tdm_emp",  m == 0 ? emp_s : emp_t, he[m]);
      end
    end
    for (int m = 0; m < 2; m++) model_step(m, a[m]);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; out_ready = 1'b1; ch_valid = '0; ch_data = '0;
    @(posedge clk);
    #1;
    cycle();
    chk("rst_sel", sel_s, 0);
    chk("rst_data", data_s, 0);
    chk("rst_vld", vld_t, 0);

    // No valid channels: round-robin side never emits.
    rst_n = 1'b1; enable = 1'b1;
    repeat (6) cycle();

    // All channels valid, data i = i.
    for (int i = 0; i < 8; i++) ch_data[i*W +: W] = W'(i);
    ch_valid = 8'hFF;
    repeat (10) cycle();

    // Two sparse channels with a backpressure window.
    ch_valid = 8'b1000_0100;
    repeat (4) cycle();
    out_ready = 1'b0;
    repeat (3) cycle();
    out_ready = 1'b1;
    repeat (3) cycle();

    // Single channel 5 carrying 1.
    ch_data = '0; ch_data[5*W +: W] = 4'd1; ch_valid = 8'h20;
    repeat (10) cycle();

    // Drop enable while stalled, then drain and restart.
    ch_valid = 8'hA5; ch_data = 32'h7654_3210;
    out_ready = 1'b0;
    repeat (2) cycle();
    enable = 1'b0;
    repeat (2) cycle();
    out_ready = 1'b1;
    repeat (3) cycle();
    enable = 1'b1;
    repeat (6) cycle();

    // Reset while an item is held.
    ch_valid = 8'hFF;
    repeat (3) cycle();
    rst_n = 1'b0;
    cycle();
    chk("midrst_vld", vld_s, 0);
    chk("midrst_sel", sel_s, 0);
    rst_n = 1'b1; ch_valid = 8'b0101_0000;
    repeat (4) cycle();

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      ch_valid  = 8'($urandom);
      ch_data   = $urandom;
      out_ready = ($urandom_range(0, 3) != 0);
      enable    = ($urandom_range(0, 15) != 0);
      rst_n     = ($urandom_range(0, 63) != 0);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
